// File: rtl/cuckoo_pkg.sv
// Shared types and default sizing for the two-table cuckoo insert store.
package cuckoo_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 10;
    localparam int DEF_NKEYS     = 8;
    localparam int DEF_MAX_KICKS = 20;
    localparam int DEF_IDX_W     = $clog2(DEF_DEPTH);

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_NOMAP = 2'd1,
        ST_FAIL  = 2'd2,
        ST_ZERO  = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_SWAP,
        S_DONE
    } fsm_state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] key;
        logic [DEF_IDX_W-1:0]  idx_a;
        logic [DEF_IDX_W-1:0]  idx_b;
    } map_entry_t;

endpackage

// File: rtl/cuckoo_key_map.sv
// Key map register file: filtered write port and lowest-index priority match.
module cuckoo_key_map
    import cuckoo_pkg::*;
#(
    parameter int NKEYS = DEF_NKEYS,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [$clog2(NKEYS)-1:0]  waddr,
    input  map_entry_t                wentry,
    input  logic [DEF_DATA_W-1:0]     lookup_key,
    output logic                      hit,
    output logic [DEF_IDX_W-1:0]      idx_a,
    output logic [DEF_IDX_W-1:0]      idx_b
);

    map_entry_t ent_q [NKEYS];
    map_entry_t ent_d [NKEYS];
    logic       wr_ok;

    assign wr_ok = (32'(wentry.idx_a) < DEPTH) && (32'(wentry.idx_b) < DEPTH);

    always_comb begin
        ent_d = ent_q;
        if (we && wr_ok) begin
            ent_d[waddr] = wentry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q <= '{default: '0};
        end else begin
            ent_q <= ent_d;
        end
    end

    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        hit   = 1'b0;
        idx_a = '0;
        idx_b = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if ((lookup_key != '0) && (ent_q[i].key == lookup_key)) begin
                hit   = 1'b1;
                idx_a = ent_q[i].idx_a;
                idx_b = ent_q[i].idx_b;
            end
        end
    end

endmodule

// File: rtl/cuckoo_insert_table.sv
// Two-table cuckoo store: insert engine with alternating A/B evictions,
// single-cycle clear and a registered read port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for ins_start; clear accepted here
// S_LOOKUP | map the carried value to its A/B slots, or finish NOMAP
// S_SWAP   | place carry into A (even cnt) or B (odd cnt), pick up old
// S_DONE   | one-cycle done pulse, results visible, back to idle
module cuckoo_insert_table
    import cuckoo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int NKEYS     = DEF_NKEYS,
    parameter int MAX_KICKS = DEF_MAX_KICKS,
    parameter int IDX_W     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     map_we,
    input  logic [$clog2(NKEYS)-1:0] map_addr,
    input  logic [DATA_W-1:0]        map_key,
    input  logic [IDX_W-1:0]         map_idx_a,
    input  logic [IDX_W-1:0]         map_idx_b,
    input  logic                     ins_start,
    input  logic [DATA_W-1:0]        ins_value,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               status,
    output logic [4:0]               kicks,
    output logic [DATA_W-1:0]        evicted,
    input  logic                     rd_table,
    input  logic [IDX_W-1:0]         rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    fsm_state_t        state_q, state_d;
    logic [DATA_W-1:0] carry_q, carry_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_a_q, idx_a_d;
    logic [IDX_W-1:0]  idx_b_q, idx_b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    status_t           status_q, status_d;
    logic [4:0]        kicks_q, kicks_d;
    logic [DATA_W-1:0] evicted_q, evicted_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] tab_a_q [DEPTH];
    logic [DATA_W-1:0] tab_a_d [DEPTH];
    logic [DATA_W-1:0] tab_b_q [DEPTH];
    logic [DATA_W-1:0] tab_b_d [DEPTH];

    logic              map_hit;
    logic [IDX_W-1:0]  map_a, map_b;
    logic [DATA_W-1:0] slot_old;
    logic [4:0]        cnt_inc;
    logic              clear_go;
    map_entry_t        wr_entry;

    assign wr_entry = '{key: map_key, idx_a: map_idx_a, idx_b: map_idx_b};

    cuckoo_key_map #(
        .NKEYS (NKEYS),
        .DEPTH (DEPTH)
    ) u_key_map (
        .clk        (clk),
        .rst        (rst),
        .we         (map_we),
        .waddr      (map_addr),
        .wentry     (wr_entry),
        .lookup_key (carry_q),
        .hit        (map_hit),
        .idx_a      (map_a),
        .idx_b      (map_b)
    );

    assign slot_old = cnt_q[0] ? tab_b_q[idx_b_q] : tab_a_q[idx_a_q];
    assign cnt_inc  = cnt_q + 5'd1;
    assign clear_go = clear && !busy_q;

    always_comb begin
        state_d   = state_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        idx_a_d   = idx_a_q;
        idx_b_d   = idx_b_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        status_d  = status_q;
        kicks_d   = kicks_q;
        evicted_d = evicted_q;
        tab_a_d   = tab_a_q;
        tab_b_d   = tab_b_q;

        if (clear_go) begin
            tab_a_d = '{default: '0};
            tab_b_d = '{default: '0};
        end

        case (state_q)
            S_IDLE: begin
                // A clear in the same cycle wins over the start.
                if (ins_start && !clear_go) begin
                    if (ins_value == '0) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        status_d  = ST_ZERO;
                        evicted_d = '0;
                        cnt_d     = '0;
                        kicks_d   = '0;
                    end else begin
                        state_d = S_LOOKUP;
                        carry_d = ins_value;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_LOOKUP: begin
                if (!map_hit) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    status_d  = ST_NOMAP;
                    evicted_d = carry_q;
                    kicks_d   = cnt_q;
                end else begin
                    state_d = S_SWAP;
                    idx_a_d = map_a;
                    idx_b_d = map_b;
                end
            end
            S_SWAP: begin
                if (cnt_q[0]) begin
                    tab_b_d[idx_b_q] = carry_q;
                end else begin
                    tab_a_d[idx_a_q] = carry_q;
                end
                carry_d = slot_old;
                cnt_d   = cnt_inc;
                if (slot_old == '0) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    status_d  = ST_OK;
                    evicted_d = '0;
                    kicks_d   = cnt_inc;
                end else if (32'(cnt_inc) == MAX_KICKS) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    status_d  = ST_FAIL;
                    evicted_d = slot_old;
                    kicks_d   = cnt_inc;
                end else begin
                    state_d = S_LOOKUP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Out-of-range read addresses return zero rather than an aliased slot.
    always_comb begin
        rd_data_d = '0;
        if (32'(rd_addr) < DEPTH) begin
            rd_data_d = rd_table ? tab_b_q[rd_addr] : tab_a_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            carry_q   <= '0;
            cnt_q     <= '0;
            idx_a_q   <= '0;
            idx_b_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            status_q  <= ST_OK;
            kicks_q   <= '0;
            evicted_q <= '0;
            rd_data_q <= '0;
            tab_a_q   <= '{default: '0};
            tab_b_q   <= '{default: '0};
        end else begin
            state_q   <= state_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            idx_a_q   <= idx_a_d;
            idx_b_q   <= idx_b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            status_q  <= status_d;
            kicks_q   <= kicks_d;
            evicted_q <= evicted_d;
            rd_data_q <= rd_data_d;
            tab_a_q   <= tab_a_d;
            tab_b_q   <= tab_b_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign status  = status_q;
    assign kicks   = kicks_q;
    assign evicted = evicted_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_cuckoo_insert_table.sv
// Bench for cuckoo_insert_table: directed steps plus random map/insert/clear
// traffic checked against an array-based model of the placement rules.
module tb_cuckoo_insert_table;

    localparam int DW    = 8;
    localparam int DEPTH = 10;
    localparam int NKEYS = 8;
    localparam int MAXK  = 20;
    localparam int IW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          map_we = 1'b0;
    logic [2:0]    map_addr = '0;
    logic [DW-1:0] map_key = '0;
    logic [IW-1:0] map_idx_a = '0;
    logic [IW-1:0] map_idx_b = '0;
    logic          ins_start = 1'b0;
    logic [DW-1:0] ins_value = '0;
    logic          busy;
    logic          done;
    logic [1:0]    status;
    logic [4:0]    kicks;
    logic [DW-1:0] evicted;
    logic          rd_table = 1'b0;
    logic [IW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;

    cuckoo_insert_table dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .map_we    (map_we),
        .map_addr  (map_addr),
        .map_key   (map_key),
        .map_idx_a (map_idx_a),
        .map_idx_b (map_idx_b),
        .ins_start (ins_start),
        .ins_value (ins_value),
        .busy      (busy),
        .done      (done),
        .status    (status),
        .kicks     (kicks),
        .evicted   (evicted),
        .rd_table  (rd_table),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int ma [DEPTH];
    int mb [DEPTH];
    int mk [NKEYS];
    int mia [NKEYS];
    int mib [NKEYS];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            ma[i] = 0;
            mb[i] = 0;
        end
        for (int i = 0; i < NKEYS; i++) begin
            mk[i] = 0;
            mia[i] = 0;
            mib[i] = 0;
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            ma[i] = 0;
            mb[i] = 0;
        end
    endfunction

    function automatic int model_find(input int v);
        int e = -1;
        if (v != 0) begin
            for (int i = NKEYS - 1; i >= 0; i--) begin
                if (mk[i] == v) e = i;
            end
        end
        return e;
    endfunction

    // Values alternate A, B, A, ... until an empty slot, a miss, or MAXK swaps.
    function automatic void model_insert(input int v, output int st, output int kk,
                                         output int ev, output int lat);
        int carry, e, old;
        bit fin;
        st = 0; kk = 0; ev = 0; lat = 1;
        if (v == 0) begin
            st = 3;
            return;
        end
        carry = v;
        fin = 0;
        while (!fin) begin
            e = model_find(carry);
            if (e < 0) begin
                st = 1; ev = carry; lat = 2 + 2 * kk; fin = 1;
            end else begin
                if (kk % 2 == 0) begin
                    old = ma[mia[e]];
                    ma[mia[e]] = carry;
                end else begin
                    old = mb[mib[e]];
                    mb[mib[e]] = carry;
                end
                kk++;
                if (old == 0) begin
                    st = 0; ev = 0; lat = 1 + 2 * kk; fin = 1;
                end else if (kk == MAXK) begin
                    st = 2; ev = old; lat = 1 + 2 * kk; fin = 1;
                end else begin
                    carry = old;
                end
            end
        end
    endfunction

    task automatic map_write(input int addr, input int key, input int a, input int b);
        map_we = 1'b1;
        map_addr = 3'(addr);
        map_key = DW'(key);
        map_idx_a = IW'(a);
        map_idx_b = IW'(b);
        tick();
        map_we = 1'b0;
        if (a < DEPTH && b < DEPTH) begin
            mk[addr] = key;
            mia[addr] = a;
            mib[addr] = b;
        end
    endtask

    task automatic do_insert(input int v, input string tag);
        int st, kk, ev, lat, n;
        model_insert(v, st, kk, ev, lat);
        ins_start = 1'b1;
        ins_value = DW'(v);
        tick();
        ins_start = 1'b0;
        if (v != 0 && lat > 1) chk({tag, "_busy"}, busy, 1);
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_status"}, status, st);
        chk({tag, "_kicks"}, kicks, kk);
        chk({tag, "_evicted"}, evicted, ev);
        chk({tag, "_busy_at_done"}, busy, 0);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic read_all(input string tag);
        int exp;
        for (int t = 0; t < 2; t++) begin
            for (int a = 0; a < 16; a++) begin
                rd_table = t[0];
                rd_addr = IW'(a);
                tick();
                exp = (a < DEPTH) ? ((t == 0) ? ma[a] : mb[a]) : 0;
                chk($sformatf("%s_rd_%s%0d", tag, (t == 0) ? "A" : "B", a), rd_data, exp);
            end
        end
    endtask

    initial begin
        int saw_done, n, st, kk, ev, lat, r;
        model_reset();

        repeat (3) tick();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_status", status, 0);
        chk("reset_kicks", kicks, 0);
        chk("reset_evicted", evicted, 0);
        chk("reset_rd_data", rd_data, 0);
        read_all("reset");

        map_write(0, 5, 2, 3);
        do_insert(5, "ins5");
        chk("ins5_kicks_one", kicks, 1);
        read_all("after5");

        map_write(1, 7, 2, 4);
        do_insert(7, "ins7");
        chk("ins7_kicks_two", kicks, 2);
        read_all("after7");

        do_insert(9, "nomap9");
        do_insert(0, "zero");
        read_all("after_nomap");

        map_write(2, 1, 0, 0);
        map_write(3, 2, 0, 0);
        map_write(4, 3, 0, 0);
        do_insert(1, "chain1");
        do_insert(2, "chain2");
        do_insert(3, "chain3");
        chk("chain3_fail", status, 2);
        chk("chain3_kicks_max", kicks, MAXK);
        read_all("after_chain");

        // Reset while the eviction chain for value 1 is mid-flight.
        ins_start = 1'b1;
        ins_value = 8'd1;
        tick();
        ins_start = 1'b0;
        saw_done = 0;
        repeat (3) begin
            tick();
            if (done === 1'b1) saw_done = 1;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("midrst_busy", busy, 0);
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) saw_done = 1;
            tick();
        end
        chk("midrst_no_done", saw_done, 0);
        read_all("midrst");

        map_write(0, 5, 2, 3);
        map_write(1, 7, 2, 4);
        do_insert(5, "pre_clr5");
        do_insert(7, "pre_clr7");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        read_all("cleared");
        do_insert(5, "post_clr5");
        rd_table = 1'b0;
        rd_addr = 4'd2;
        tick();
        chk("post_clr5_A2", rd_data, 5);

        // Clear and start together: the clear wins.
        clear = 1'b1;
        ins_start = 1'b1;
        ins_value = 8'd7;
        tick();
        clear = 1'b0;
        ins_start = 1'b0;
        model_clear();
        chk("clr_start_busy", busy, 0);
        tick();
        chk("clr_start_done", done, 0);
        read_all("clr_start");

        // Clear while busy is ignored.
        model_insert(7, st, kk, ev, lat);
        ins_start = 1'b1;
        ins_value = 8'd7;
        tick();
        ins_start = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n = 2;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("busyclr_latency", n, lat);
        chk("busyclr_status", status, st);
        tick();
        read_all("busyclr");

        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                map_write($urandom_range(0, NKEYS - 1), $urandom_range(0, 12),
                          $urandom_range(0, 11), $urandom_range(0, 11));
            end else if (r == 3) begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
                model_clear();
            end else begin
                do_insert($urandom_range(0, 12), $sformatf("rnd%0d", it));
            end
        end
        read_all("rnd_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cuckoo_insert_table.md
Name: cuckoo_insert_table

Overview:
Two-table cuckoo-style hash store. It holds table A and table B, each DEPTH entries of DATA_W bits, where value 0 means an empty slot. A programmable key map (NKEYS entries) gives each key its slot index in A and in B. An insert engine places a value into A at its mapped slot; any displaced occupant is kicked to its B slot, and so on alternately, up to MAX_KICKS swaps. The block also provides a clear (initialize) operation and a registered read port. It sits as the storage/placement back-end behind a controller that issues inserts.

Parameters:
DATA_W, 8, width of stored values and keys
DEPTH, 10, entries per table (A and B)
NKEYS, 8, key-map entries
MAX_KICKS, 20, maximum swaps per insert
IDX_W, $clog2(DEPTH)=4, slot index width (derived)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
clear  in  1  pulse; zero both tables
map_we  in  1  write key-map entry
map_addr  in  $clog2(NKEYS)  key-map entry index
map_key  in  DATA_W  key stored in entry
map_idx_a  in  IDX_W  slot in table A for key
map_idx_b  in  IDX_W  slot in table B for key
ins_start  in  1  start insert (accepted only when !busy)
ins_value  in  DATA_W  value to insert
busy  out  1  insert in progress
done  out  1  one-cycle completion pulse
status  out  2  0=OK, 1=NOMAP, 2=FAIL, 3=ZERO
kicks  out  5  swaps performed by the last insert
evicted  out  DATA_W  value left homeless on FAIL/NOMAP, else 0
rd_table  in  1  0=A, 1=B
rd_addr  in  IDX_W  read slot
rd_data  out  DATA_W  registered read data, 1-cycle latency

Behaviour:
- Reset:
  - Tables A/B all 0; key map keys 0, indices 0.
  - busy=0, done=0, status=0, kicks=0, evicted=0, rd_data=0, FSM=IDLE.
  - Reset mid-insert aborts it; no done pulse.
- clear: zeroes every A/B slot in one cycle. Ignored while busy. Key map is untouched.
- map_we:
  - Writes the entry when map_idx_a<DEPTH and map_idx_b<DEPTH; otherwise the write is ignored.
  - Allowed while busy; takes effect on the next lookup.
- Lookup (combinational):
  - Finds the lowest-index map entry whose key equals the carried value.
  - Miss when there is no match. Key 0 never matches.
- FSM: IDLE, LOOKUP, SWAP, DONE.
  - IDLE: on ins_start, if ins_value==0, go to DONE with status=ZERO and evicted=0. Otherwise latch carry=ins_value, cnt=0, set busy=1, go to LOOKUP.
  - LOOKUP: on miss, go to DONE with status=NOMAP and evicted=carry. On hit, latch idx_a/idx_b and go to SWAP.
  - SWAP: target table = A when cnt even, B when odd; slot = idx_a or idx_b.
    - Write carry into the slot, set carry to the old slot content, cnt=cnt+1.
    - If the old content is 0: DONE with status=OK, evicted=0.
    - Else if cnt+1==MAX_KICKS: DONE with status=FAIL, evicted=old content.
    - Else go to LOOKUP.
  - DONE: done=1 for one cycle, busy=0, kicks=cnt; return to IDLE. status, kicks and evicted hold until the next completion.
- Latency: an insert into an empty A slot is accepted in cycle T; done is asserted in cycle T+3. Each extra kick adds 2 cycles.
- ins_start while busy is ignored. A simultaneous clear and ins_start in IDLE runs the clear and ignores the start.
- Read port:
  - rd_data <= selected table[rd_addr] every cycle.
  - rd_addr>=DEPTH returns 0.
  - A read in the same cycle as a write returns the old value.

Decomposition:
- Shared package cuckoo_pkg holds:
  - status enum (ST_OK, ST_NOMAP, ST_FAIL, ST_ZERO);
  - FSM state enum;
  - the DATA_W / DEPTH / NKEYS / MAX_KICKS defaults;
  - a map_entry_t struct {key, idx_a, idx_b}.
- One sub-module, cuckoo_key_map: the NKEYS-entry register file with a write port and a combinational priority-match lookup returning hit, idx_a, idx_b.
- Tables and FSM stay in the top module.

Test Plan:
- Reset, then read every slot of A and B -> all rd_data=0; busy=0, done=0.
- Map 5->(2,3); insert 5 -> done at T+3, status=OK, kicks=1, A[2]=5, B all 0.
- Map 5->(2,3) and 7->(2,4); insert 5, then insert 7 -> second insert status=OK, kicks=2, A[2]=7, B[3]=5.
- Insert 9 with no map entry -> status=NOMAP, evicted=9, tables unchanged. Insert 0 -> status=ZERO, done the next cycle.
- Map 1, 2 and 3 all ->(0,0); insert 1, 2, 3 -> third insert status=FAIL, kicks=20, evicted nonzero, A[0] and B[0] nonzero.
- Assert rst during the SWAP of an eviction chain -> tables zero, busy=0, no done. clear pulsed while idle -> all slots 0, key map intact (re-insert 5 lands in A[2]).
